// File: rtl/pong_ball_controller.sv
// Pong ball sequencer: per-frame paddle checks, wall bounce, move, scoring.
// Ports: clk/rst, frame_tick/start in, paddle ALU velocities in;
//        ball position/velocity, scores, busy, game_over out.
module pong_ball_controller #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BALL_SIZE     = 10,
    parameter int INIT_VX       = 2,
    parameter int INIT_VY       = 2,
    parameter int SERVE_FRAMES  = 60,
    parameter int WIN_SCORE     = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [15:0] Paddle1_Y,
    input  logic [15:0] Paddle2_Y,
    input  logic [15:0] alu1_vx,
    input  logic [15:0] alu1_vy,
    input  logic [15:0] alu2_vx,
    input  logic [15:0] alu2_vy,
    output logic [15:0] Ball_X,
    output logic [15:0] Ball_Y,
    output logic [15:0] Ball_Vx,
    output logic [15:0] Ball_Vy,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic        busy,
    output logic        game_over
);

    typedef enum logic [2:0] {
        IDLE, SERVE, WAIT_TICK, P1_CHK,
        P2_CHK, WALL_CHK, MOVE, SCORE
    } state_t;

    localparam logic [15:0] XC = 16'((SCREEN_WIDTH - BALL_SIZE) / 2);
    localparam logic [15:0] YC = 16'((SCREEN_HEIGHT - BALL_SIZE) / 2);
    localparam logic [15:0] YMAX16 = 16'(SCREEN_HEIGHT - BALL_SIZE);
    localparam logic signed [17:0] XMAX = 18'(SCREEN_WIDTH - BALL_SIZE);
    localparam logic signed [17:0] YMAX = 18'(SCREEN_HEIGHT - BALL_SIZE);
    localparam logic [15:0] VX0 = 16'(INIT_VX);
    localparam logic [15:0] VY0 = 16'(INIT_VY);
    localparam logic [3:0]  WIN = 4'(WIN_SCORE);
    localparam logic [15:0] SERVE_LAST = 16'(SERVE_FRAMES - 1);

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  s1_q, s1_d, s2_q, s2_d;
    logic        busy_q, busy_d, go_q, go_d;
    logic        p2pt_q, p2pt_d;
    logic signed [17:0] nx, ny;

    // Paddle positions only feed the external ALUs.
    logic unused_paddles;
    assign unused_paddles = ^{Paddle1_Y, Paddle2_Y};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        busy_d  = busy_q;
        go_d    = go_q;
        p2pt_d  = p2pt_q;
        nx = $signed({2'b00, x_q}) + $signed({{2{vx_q[15]}}, vx_q});
        ny = $signed({2'b00, y_q}) + $signed({{2{vy_q[15]}}, vy_q});
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    s1_d    = '0;
                    s2_d    = '0;
                    go_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == SERVE_LAST) state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (frame_tick) begin
                    busy_d  = 1'b1;
                    state_d = P1_CHK;
                end
            end
            P1_CHK: begin
                if (vx_q[15]) begin
                    vx_d = alu1_vx;
                    vy_d = alu1_vy;
                end
                state_d = P2_CHK;
            end
            P2_CHK: begin
                if (!vx_q[15] && vx_q != '0) begin
                    vx_d = alu2_vx;
                    vy_d = alu2_vy;
                end
                state_d = WALL_CHK;
            end
            WALL_CHK: begin
                if (ny < 0 || ny > YMAX) vy_d = -vy_q;
                state_d = MOVE;
            end
            MOVE: begin
                if (ny < 0)         y_d = '0;
                else if (ny > YMAX) y_d = YMAX16;
                else                y_d = ny[15:0];
                if (nx < 0) begin
                    if (s2_q < WIN) s2_d = s2_q + 4'd1;
                    p2pt_d  = 1'b1;
                    state_d = SCORE;
                end else if (nx > XMAX) begin
                    if (s1_q < WIN) s1_d = s1_q + 4'd1;
                    p2pt_d  = 1'b0;
                    state_d = SCORE;
                end else begin
                    x_d     = nx[15:0];
                    busy_d  = 1'b0;
                    state_d = WAIT_TICK;
                end
            end
            SCORE: begin
                x_d    = XC;
                y_d    = YC;
                vy_d   = VY0;
                // Serve toward the player who just missed.
                vx_d   = p2pt_q ? -VX0 : VX0;
                busy_d = 1'b0;
                if ((p2pt_q ? s2_q : s1_q) == WIN) begin
                    go_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= XC;
            y_q     <= YC;
            vx_q    <= VX0;
            vy_q    <= VY0;
            cnt_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            busy_q  <= 1'b0;
            go_q    <= 1'b0;
            p2pt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            cnt_q   <= cnt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            busy_q  <= busy_d;
            go_q    <= go_d;
            p2pt_q  <= p2pt_d;
        end
    end

    assign Ball_X    = x_q;
    assign Ball_Y    = y_q;
    assign Ball_Vx   = vx_q;
    assign Ball_Vy   = vy_q;
    assign score1    = s1_q;
    assign score2    = s2_q;
    assign busy      = busy_q;
    assign game_over = go_q;

endmodule
